// File: rtl/mult_add_tree_pkg.sv
// Shared helpers for the mult_add_tree pipeline: latency and the per-stage
// add/multiply rules. Define MULT_ADD_TREE_SATURATE_EN to clamp instead of wrap.
package mult_add_tree_pkg;

  // Widest operand the helpers carry; the top rejects wider WIDTH values.
  localparam int MAX_W = 64;

  function automatic int latency(input int num_inputs);
    return 2 + $clog2(num_inputs / 2);
  endfunction

  function automatic logic [MAX_W-1:0] width_mask(input int width);
    return (width >= MAX_W) ? {MAX_W{1'b1}} : ((MAX_W'(1) << width) - MAX_W'(1));
  endfunction

  function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input int width);
`ifdef MULT_ADD_TREE_SATURATE_EN
    logic [MAX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, width_mask(width)}) ? width_mask(width) : s[MAX_W-1:0];
`else
    return (a + b) & width_mask(width);
`endif
  endfunction

  function automatic logic [MAX_W-1:0] sat_mul(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input int width);
`ifdef MULT_ADD_TREE_SATURATE_EN
    logic [2*MAX_W-1:0] p;
    p = (2*MAX_W)'(a) * (2*MAX_W)'(b);
    return (p > (2*MAX_W)'(width_mask(width))) ? width_mask(width) : p[MAX_W-1:0];
`else
    return (a * b) & width_mask(width);
`endif
  endfunction

endpackage

// File: rtl/mult_add_tree_level.sv
// One registered reduction level of the adder tree: N packed inputs in,
// N/2 pairwise sums out, updated only when the pipeline advances.
module mult_add_tree_level
  import mult_add_tree_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_adv,
  input  logic [N*WIDTH-1:0]       i_data,
  output logic [(N/2)*WIDTH-1:0]   o_sum
);

  logic [(N/2)*WIDTH-1:0] w_sum;
  logic [(N/2)*WIDTH-1:0] r_sum;

  always_comb begin
    // NOTE: default first so no path through the block leaves w_sum unassigned (no latch).
    w_sum = '0;
    for (int j = 0; j < N / 2; j++) begin
      w_sum[j*WIDTH +: WIDTH] = WIDTH'(sat_add(MAX_W'(i_data[(2*j)*WIDTH +: WIDTH]),
                                               MAX_W'(i_data[(2*j+1)*WIDTH +: WIDTH]),
                                               WIDTH));
    end
  end

  // NOTE: non-blocking so every level samples its neighbour's pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_sum <= '0;
    else if (i_adv) r_sum <= w_sum;
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/mult_add_tree.sv
// Pipelined multiply-add tree with valid/ready handshake and whole-pipeline stall.
// Define MULT_ADD_TREE_SATURATE_EN for per-stage unsigned saturation.
module mult_add_tree
  import mult_add_tree_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int NUM_INPUTS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in [NUM_INPUTS],
  input  logic             valid_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] out,
  output logic             valid_out,
  input  logic             ready_in
);

  localparam int NPROD   = NUM_INPUTS / 2;
  localparam int LEVELS  = $clog2(NPROD);
  localparam int LATENCY = latency(NUM_INPUTS);

  if (NUM_INPUTS < 2 || (NUM_INPUTS & (NUM_INPUTS - 1)) != 0) begin : g_bad_num_inputs
    $error("mult_add_tree: NUM_INPUTS must be a power of two >= 2");
  end
  if (WIDTH < 2 || WIDTH > MAX_W) begin : g_bad_width
    $error("mult_add_tree: WIDTH out of range");
  end

  logic                   w_adv;
  logic [WIDTH-1:0]       r_in [NUM_INPUTS];
  logic [NPROD*WIDTH-1:0] w_mult;
  logic [NPROD*WIDTH-1:0] r_mult;
  logic [LATENCY-1:0]     r_valid;

  // A stall only ever comes from a held, unconsumed result at the output.
  assign w_adv     = !r_valid[LATENCY-1] || ready_in;
  assign ready_out = w_adv;
  assign valid_out = r_valid[LATENCY-1];

  // NOTE: the operand array is reset too, so no pre-reset data can reach out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_INPUTS; i++) r_in[i] <= '0;
      r_valid <= '0;
    end else if (w_adv) begin
      for (int i = 0; i < NUM_INPUTS; i++) r_in[i] <= in[i];
      r_valid <= {r_valid[LATENCY-2:0], valid_in};
    end
  end

  always_comb begin
    w_mult = '0;
    for (int i = 0; i < NPROD; i++) begin
      w_mult[i*WIDTH +: WIDTH] = WIDTH'(sat_mul(MAX_W'(r_in[2*i]), MAX_W'(r_in[2*i+1]), WIDTH));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_mult <= '0;
    else if (w_adv) r_mult <= w_mult;
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int N = NPROD >> k;
    logic [(N/2)*WIDTH-1:0] w_sum;
    if (k == 0) begin : g_first
      mult_add_tree_level #(.WIDTH(WIDTH), .N(N)) u_level (
        .clk   (clk),
        .rst   (rst),
        .i_adv (w_adv),
        .i_data(r_mult),
        .o_sum (w_sum)
      );
    end else begin : g_next
      mult_add_tree_level #(.WIDTH(WIDTH), .N(N)) u_level (
        .clk   (clk),
        .rst   (rst),
        .i_adv (w_adv),
        .i_data(g_lvl[k-1].w_sum),
        .o_sum (w_sum)
      );
    end
  end

  // With two inputs the multiply register is itself the output register.
  if (LEVELS == 0) begin : g_out_mult
    assign out = r_mult;
  end else begin : g_out_tree
    assign out = g_lvl[LEVELS-1].w_sum;
  end

endmodule
